// File: rtl/spi_target_mode3_if.sv
// spi_target_mode3_if: SPI pins plus TX/RX byte handshakes and status of the mode 3 SPI target
interface spi_target_mode3_if #(
    parameter int CFG_FIFO_DEPTH = 4
);
    localparam int CW = $clog2(CFG_FIFO_DEPTH) + 1;
    logic          SPISCLKI;
    logic          SPISSI;
    logic          SPISDI;
    logic          SPISDO;
    logic          SPIOEN;
    logic [7:0]    TXDATA;
    logic          TXVALID;
    logic          TXREADY;
    logic [7:0]    RXDATA;
    logic          RXVALID;
    logic          RXREADY;
    logic          TXUNDERRUN;
    logic          RXOVERRUN;
    logic          FRAMEERR;
    logic          BUSY;
    logic [CW-1:0] TXCOUNT;
    modport slave (
        input  SPISCLKI, SPISSI, SPISDI, TXDATA, TXVALID, RXREADY,
        output SPISDO, SPIOEN, TXREADY, RXDATA, RXVALID, TXUNDERRUN, RXOVERRUN, FRAMEERR, BUSY, TXCOUNT
    );
    modport master (
        output SPISCLKI, SPISSI, SPISDI, TXDATA, TXVALID, RXREADY,
        input  SPISDO, SPIOEN, TXREADY, RXDATA, RXVALID, TXUNDERRUN, RXOVERRUN, FRAMEERR, BUSY, TXCOUNT
    );
endinterface

// File: rtl/spi_target_mode3.sv
// spi_target_mode3: oversampled SPI mode 3 target with TX FIFO and RX output register
module spi_target_mode3 #(
    parameter int         CFG_FIFO_DEPTH    = 4,
    parameter logic [7:0] CFG_UNDERRUN_BYTE = 8'hFF
) (
    input logic PCLK,
    input logic PRESET,
    spi_target_mode3_if.slave bus
);
    localparam int AW = $clog2(CFG_FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, BYTE_START, SHIFT} state_t;

    state_t        state, state_n;
    logic [2:0]    sclk_q, ss_q;
    logic [1:0]    sdi_q;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_shift, rx_shift, rx_data;
    logic          rx_valid, underrun, overrun, frame_err;
    logic [7:0]    mem [CFG_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          load, rx_sh, tx_sh, done, ferr;

    // Edges come from synchroniser output vs. history flop, so they act 3 cycles after the pin
    wire sclk_rise = sclk_q[1] & ~sclk_q[2];
    wire sclk_fall = ~sclk_q[1] & sclk_q[2];
    wire ss_rise   = ss_q[1] & ~ss_q[2];
    wire ss_fall   = ~ss_q[1] & ss_q[2];
    wire empty     = count == '0;
    wire push      = bus.TXVALID && bus.TXREADY;
    wire pop       = load && !empty;
    wire [7:0] rx_byte = {rx_shift[6:0], sdi_q[1]};

    always_comb begin
        state_n = state;
        load    = 1'b0;
        rx_sh   = 1'b0;
        tx_sh   = 1'b0;
        done    = 1'b0;
        ferr    = 1'b0;
        if (ss_rise) begin
            state_n = IDLE;
            ferr    = state == SHIFT && bit_cnt != '0;
        end else begin
            case (state)
                IDLE:       state_n = ss_fall ? BYTE_START : IDLE;
                BYTE_START: begin
                    load    = sclk_fall;
                    state_n = sclk_fall ? SHIFT : BYTE_START;
                end
                SHIFT:      begin
                    rx_sh   = sclk_rise;
                    tx_sh   = sclk_fall && bit_cnt != '0;
                    done    = sclk_rise && bit_cnt == 3'd7;
                    state_n = done ? BYTE_START : SHIFT;
                end
                default:    state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            sclk_q    <= 3'b111;
            ss_q      <= 3'b111;
            sdi_q     <= 2'b00;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_n;
            sclk_q    <= {sclk_q[1:0], bus.SPISCLKI};
            ss_q      <= {ss_q[1:0], bus.SPISSI};
            sdi_q     <= {sdi_q[0], bus.SPISDI};
            bit_cnt   <= (ss_rise || state == IDLE) ? '0 : rx_sh ? bit_cnt + 3'd1 : bit_cnt;
            tx_shift  <= load ? (empty ? CFG_UNDERRUN_BYTE : mem[rd_ptr]) :
                         tx_sh ? {tx_shift[6:0], 1'b0} : tx_shift;
            rx_shift  <= rx_sh ? rx_byte : rx_shift;
            underrun  <= load && empty;
            overrun   <= done && rx_valid && !bus.RXREADY;
            frame_err <= ferr;
            // A completed byte may land in the same cycle the consumer takes the old one
            if (done && (!rx_valid || bus.RXREADY)) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
            end else if (bus.RXREADY) begin
                rx_valid <= 1'b0;
            end
            wr_ptr    <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count     <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr] <= bus.TXDATA;
    end

    assign bus.SPISDO     = tx_shift[7];
    assign bus.SPIOEN     = state != IDLE;
    assign bus.BUSY       = state != IDLE;
    assign bus.TXREADY    = count < CW'(CFG_FIFO_DEPTH);
    assign bus.TXCOUNT    = count;
    assign bus.RXDATA     = rx_data;
    assign bus.RXVALID    = rx_valid;
    assign bus.TXUNDERRUN = underrun;
    assign bus.RXOVERRUN  = overrun;
    assign bus.FRAMEERR   = frame_err;
endmodule

// File: tb/tb_spi_target_mode3.sv
// tb_spi_target_mode3: directed SPI mode 3 master with queued MISO/RX expectations
module tb_spi_target_mode3;
    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    int   total = 0, passed = 0;
    int   ur_cnt = 0, ov_cnt = 0, fe_cnt = 0, mbits = 0;
    logic [7:0] mbyte = '0;
    logic [7:0] rx_q[$], miso_q[$];

    spi_target_mode3_if #(.CFG_FIFO_DEPTH(4)) bus();
    spi_target_mode3 #(.CFG_FIFO_DEPTH(4), .CFG_UNDERRUN_BYTE(8'hFF)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .bus(bus));

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge PCLK) begin
        if (bus.TXUNDERRUN === 1'b1) ur_cnt++;
        if (bus.RXOVERRUN === 1'b1) ov_cnt++;
        if (bus.FRAMEERR === 1'b1) fe_cnt++;
    end

    // RX monitor: every accepted byte must match the next expected one
    always @(negedge PCLK) begin
        if (!PRESET && bus.RXVALID === 1'b1 && bus.RXREADY === 1'b1) begin
            if (rx_q.size() == 0) begin
                total++;
                $display("FAIL rx_unexpected: got %0h expected none", bus.RXDATA);
            end else chk("rxdata", 32'(bus.RXDATA), 32'(rx_q.pop_front()));
        end
    end

    // MISO monitor: master samples on rising SCLK; partial bytes discarded on SS release
    always @(posedge bus.SPISCLKI or posedge bus.SPISSI) begin
        if (bus.SPISSI === 1'b1) mbits = 0;
        else if (bus.SPISSI === 1'b0) begin
            mbyte = {mbyte[6:0], bus.SPISDO};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (miso_q.size() == 0) begin
                    total++;
                    $display("FAIL miso_unexpected: got %0h expected none", mbyte);
                end else chk("miso", 32'(mbyte), 32'(miso_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic push(input logic [7:0] d);
        bus.TXDATA = d;
        bus.TXVALID = 1'b1;
        tick(1);
        bus.TXVALID = 1'b0;
    endtask

    task automatic bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.SPISCLKI = 1'b0;
            bus.SPISDI = b[7-i];
            tick(4);
            bus.SPISCLKI = 1'b1;
            tick(4);
        end
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int n);
        bus.SPISSI = 1'b0;
        tick(4);
        bits(b0, 8);
        if (n > 1) begin
            tick(4);
            bits(b1, 8);
        end
        tick(8);
        bus.SPISSI = 1'b1;
        tick(8);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sdo"}, 32'(bus.SPISDO), 0);
        chk({tag, "_oen"}, 32'(bus.SPIOEN), 0);
        chk({tag, "_busy"}, 32'(bus.BUSY), 0);
        chk({tag, "_rxvalid"}, 32'(bus.RXVALID), 0);
        chk({tag, "_rxdata"}, 32'(bus.RXDATA), 0);
        chk({tag, "_txready"}, 32'(bus.TXREADY), 1);
        chk({tag, "_txcount"}, 32'(bus.TXCOUNT), 0);
        chk({tag, "_pulses"}, 32'({bus.TXUNDERRUN, bus.RXOVERRUN, bus.FRAMEERR}), 0);
    endtask

    initial begin
        bus.SPISCLKI = 1'b1;
        bus.SPISSI = 1'b1;
        bus.SPISDI = 1'b0;
        bus.TXDATA = '0;
        bus.TXVALID = 1'b0;
        bus.RXREADY = 1'b1;
        tick(3);
        chk_reset_outputs("reset");
        PRESET = 1'b0;
        tick(2);

        // Two-byte burst with preloaded FIFO
        push(8'hA5);
        push(8'h3C);
        chk("t1_txcount", 32'(bus.TXCOUNT), 2);
        miso_q.push_back(8'hA5); miso_q.push_back(8'h3C);
        rx_q.push_back(8'h5A);   rx_q.push_back(8'hC3);
        bus.SPISSI = 1'b0;
        tick(4);
        chk("t1_busy", 32'(bus.BUSY), 1);
        chk("t1_oen", 32'(bus.SPIOEN), 1);
        bits(8'h5A, 8);
        tick(4);
        bits(8'hC3, 8);
        tick(8);
        bus.SPISSI = 1'b1;
        tick(8);
        chk("t1_idle_busy", 32'(bus.BUSY), 0);
        chk("t1_flags", 32'(ur_cnt + ov_cnt + fe_cnt), 0);
        chk("t1_txcount_end", 32'(bus.TXCOUNT), 0);

        // Underrun on empty FIFO
        miso_q.push_back(8'hFF); rx_q.push_back(8'h96);
        frame(8'h96, 8'h00, 1);
        chk("t2_underrun", 32'(ur_cnt), 1);

        // Overrun while consumer stalls
        bus.RXREADY = 1'b0;
        miso_q.push_back(8'hFF); miso_q.push_back(8'hFF);
        rx_q.push_back(8'h11);
        frame(8'h11, 8'h22, 2);
        chk("t3_rxdata", 32'(bus.RXDATA), 32'h11);
        chk("t3_rxvalid", 32'(bus.RXVALID), 1);
        chk("t3_overrun", 32'(ov_cnt), 1);
        chk("t3_underrun", 32'(ur_cnt), 3);
        bus.RXREADY = 1'b1;
        tick(2);
        chk("t3_rxvalid_clr", 32'(bus.RXVALID), 0);

        // Frame aborted after 5 bits, then a clean frame
        bus.SPISSI = 1'b0;
        tick(4);
        bits(8'hF0, 5);
        tick(4);
        bus.SPISSI = 1'b1;
        tick(8);
        chk("t4_frameerr", 32'(fe_cnt), 1);
        chk("t4_rxvalid", 32'(bus.RXVALID), 0);
        chk("t4_underrun", 32'(ur_cnt), 4);
        miso_q.push_back(8'hFF); rx_q.push_back(8'h0F);
        frame(8'h0F, 8'h00, 1);
        chk("t4_frameerr_end", 32'(fe_cnt), 1);

        // FIFO full behaviour
        push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
        chk("t5_count_full", 32'(bus.TXCOUNT), 4);
        chk("t5_ready_full", 32'(bus.TXREADY), 0);
        push(8'hD4);
        chk("t5_count_refused", 32'(bus.TXCOUNT), 4);
        miso_q.push_back(8'hD0); rx_q.push_back(8'h44);
        frame(8'h44, 8'h00, 1);
        chk("t5_count_after", 32'(bus.TXCOUNT), 3);
        chk("t5_ready_after", 32'(bus.TXREADY), 1);
        chk("t5_underrun", 32'(ur_cnt), 5);

        // Reset mid-byte flushes FIFO and aborts silently
        bus.SPISSI = 1'b0;
        tick(4);
        bits(8'hAA, 3);
        PRESET = 1'b1;
        bus.SPISSI = 1'b1;
        tick(1);
        chk_reset_outputs("t6");
        PRESET = 1'b0;
        tick(4);
        miso_q.push_back(8'hFF); rx_q.push_back(8'h81);
        frame(8'h81, 8'h00, 1);
        chk("t6_frameerr", 32'(fe_cnt), 1);
        chk("t6_underrun", 32'(ur_cnt), 6);

        tick(4);
        chk("rx_q_drained", 32'(rx_q.size()), 0);
        chk("miso_q_drained", 32'(miso_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
